// File: rtl/hamming_in_stage_if.sv
// hamming_in_stage_if: serial Hamming encoder stage signals; HAM_XPAR_EN widens codereg to 16 bits.
interface hamming_in_stage_if;
`ifdef HAM_XPAR_EN
  localparam int CW = 16;
`else
  localparam int CW = 15;
`endif
  logic          shift;
  logic          sl_in;
  logic          sl_out;
  logic [10:0]   datareg;
  logic [CW-1:0] codereg;
  logic [3:0]    bitcnt;
  logic          sending;
  logic          done;
  modport master(output shift, sl_in, input sl_out, datareg, codereg, bitcnt, sending, done);
  modport slave(input shift, sl_in, output sl_out, datareg, codereg, bitcnt, sending, done);
endinterface

// File: rtl/hamming_in_stage.sv
// hamming_in_stage: collects 11 serial data bits, Hamming(15,11) encodes them and streams c15 first.
// HAM_XPAR_EN appends overall even parity c0 as a 16th bit sent last.
module hamming_in_stage (
  input logic               clk,
  input logic               RST,
  hamming_in_stage_if.slave bus
);
`ifdef HAM_XPAR_EN
  localparam int N = 16;
`else
  localparam int N = 15;
`endif
  localparam logic [3:0] LAST = 4'(N - 1);
  typedef enum logic [1:0] {LOAD, ENCODE, SEND} state_t;
  state_t       state_q, state_d;
  logic [10:0]  datareg_q, datareg_d;
  logic [N-1:0] codereg_q, codereg_d, cw_full;
  logic [3:0]   bitcnt_q, bitcnt_d, idx;
  logic         sl_out_q, sl_out_d, done_q, done_d, last;
  logic [15:1]  cd, cw;
  always_comb begin
    cd = {datareg_q[10:4], 1'b0, datareg_q[3:1], 1'b0, datareg_q[0], 2'b0};
    cw = cd;
    cw[1] = ^(cd & 15'h5555);
    cw[2] = ^(cd & 15'h6666);
    cw[4] = ^(cd & 15'h7878);
    cw[8] = ^(cd & 15'h7F80);
`ifdef HAM_XPAR_EN
    cw_full = {cw, ^cw};
`else
    cw_full = cw;
`endif
  end
  // codereg stays static; the bit after the one on sl_out is picked by index
  assign idx  = 4'(N - 2) - bitcnt_q;
  assign last = bitcnt_q == LAST;
  always_comb begin
    state_d   = state_q;
    datareg_d = datareg_q;
    codereg_d = codereg_q;
    bitcnt_d  = bitcnt_q;
    sl_out_d  = sl_out_q;
    done_d    = 1'b0;
    case (state_q)
      LOAD: if (bus.shift) begin
        datareg_d = {datareg_q[9:0], bus.sl_in};
        bitcnt_d  = bitcnt_q == 4'd10 ? 4'd0 : bitcnt_q + 4'd1;
        state_d   = bitcnt_q == 4'd10 ? ENCODE : LOAD;
      end
      ENCODE: begin
        codereg_d = cw_full;
        sl_out_d  = cw_full[N-1];
        bitcnt_d  = 4'd0;
        state_d   = SEND;
      end
      SEND: if (bus.shift) begin
        sl_out_d = last ? 1'b0 : codereg_q[idx];
        bitcnt_d = last ? 4'd0 : bitcnt_q + 4'd1;
        done_d   = last;
        state_d  = last ? LOAD : SEND;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= LOAD;
      datareg_q <= '0;
      codereg_q <= '0;
      bitcnt_q  <= '0;
      sl_out_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      datareg_q <= datareg_d;
      codereg_q <= codereg_d;
      bitcnt_q  <= bitcnt_d;
      sl_out_q  <= sl_out_d;
      done_q    <= done_d;
    end
  end
  assign bus.sl_out  = sl_out_q;
  assign bus.datareg = datareg_q;
  assign bus.codereg = codereg_q;
  assign bus.bitcnt  = bitcnt_q;
  assign bus.sending = state_q == SEND;
  assign bus.done    = done_q;
endmodule
